// File: rtl/load_store_unit_if.sv
// Request, memory-bus and response signals of the load/store unit.
// slave is the load/store unit itself; master is the execute stage, memory and consumer.
interface load_store_unit_if #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned DataWidth = 4 * BYTE_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DataWidth-1:0]  req_wdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DataWidth-1:0]  mem_wdata;
    logic                  mem_ack;
    logic                  mem_err;
    logic [DataWidth-1:0]  mem_rdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_is_load;
    logic [3:0]            ldst_mask;
    logic [1:0]            offset;
    logic                  ldst_is_unsigned;
    logic [DataWidth-1:0]  memory_out;
    logic                  misaligned;
    logic                  access_fault;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_err, mem_rdata,
        output rsp_valid, rsp_is_load, ldst_mask, offset, ldst_is_unsigned,
        output memory_out, misaligned, access_fault,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_err, mem_rdata,
        input  rsp_valid, rsp_is_load, ldst_mask, offset, ldst_is_unsigned,
        input  memory_out, misaligned, access_fault,
        output rsp_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front end: checks one request at a time, runs a single word-addressed
// bus cycle guarded by a watchdog, and returns the raw word plus lane information.
module load_store_unit #(
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave lsu_if
);
    localparam int unsigned DataWidth = 4 * BYTE_WIDTH;
    localparam int unsigned CntWidth  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth:0] TimeoutVal = (CntWidth + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e state_q, state_d;

    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [CntWidth:0]     cnt_inc;
    logic                  expired;

    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0]  mem_wdata_q, mem_wdata_d;

    logic                  rsp_is_load_q, rsp_is_load_d;
    logic [3:0]            ldst_mask_q, ldst_mask_d;
    logic [1:0]            offset_q, offset_d;
    logic                  unsigned_q, unsigned_d;
    logic [DataWidth-1:0]  memory_out_q, memory_out_d;
    logic                  misaligned_q, misaligned_d;
    logic                  access_fault_q, access_fault_d;

    logic [3:0]            size_mask;
    logic                  legal;
    logic                  aligned;
    logic                  accept;
    logic [1:0]            req_off;

    assign req_off = lsu_if.req_addr[1:0];
    assign accept  = (state_q == StIdle) && lsu_if.req_valid;

    // Unsigned sizes (100/101) exist only for loads.
    always_comb begin
        size_mask = 4'b0000;
        legal     = 1'b0;
        case (lsu_if.req_funct3)
            3'b000: begin size_mask = 4'b0001; legal = 1'b1; end
            3'b001: begin size_mask = 4'b0011; legal = 1'b1; end
            3'b010: begin size_mask = 4'b1111; legal = 1'b1; end
            3'b100: begin size_mask = 4'b0001; legal = !lsu_if.req_is_store; end
            3'b101: begin size_mask = 4'b0011; legal = !lsu_if.req_is_store; end
            default: ;
        endcase
        aligned = !(((size_mask == 4'b0011) && req_off[0]) ||
                    ((size_mask == 4'b1111) && (req_off != 2'b00)));
    end

    // The ack in the expiry cycle wins over the watchdog.
    assign cnt_inc = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
    assign expired = (state_q == StBus) && !lsu_if.mem_ack && (cnt_inc == TimeoutVal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (lsu_if.req_valid) state_d = (legal && aligned) ? StBus : StResp;
            StBus:  if (lsu_if.mem_ack || expired) state_d = StResp;
            StResp: if (lsu_if.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lsu_if.req_ready = (state_q == StIdle);
        lsu_if.mem_req   = (state_q == StBus);
        lsu_if.rsp_valid = (state_q == StResp);
    end

    always_comb begin
        cnt_d          = cnt_q;
        mem_we_d       = mem_we_q;
        mem_be_d       = mem_be_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        rsp_is_load_d  = rsp_is_load_q;
        ldst_mask_d    = ldst_mask_q;
        offset_d       = offset_q;
        unsigned_d     = unsigned_q;
        memory_out_d   = memory_out_q;
        misaligned_d   = misaligned_q;
        access_fault_d = access_fault_q;
        if (accept) begin
            rsp_is_load_d  = !lsu_if.req_is_store;
            offset_d       = req_off;
            unsigned_d     = lsu_if.req_funct3[2] && !lsu_if.req_funct3[1];
            memory_out_d   = '0;
            access_fault_d = 1'b0;
            misaligned_d   = !(legal && aligned);
            ldst_mask_d    = (legal && aligned && !lsu_if.req_is_store) ? size_mask : 4'b0000;
            if (legal && aligned) begin
                cnt_d       = '0;
                mem_we_d    = lsu_if.req_is_store;
                mem_be_d    = lsu_if.req_is_store ? (size_mask << req_off) : 4'b1111;
                mem_addr_d  = {lsu_if.req_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_d = lsu_if.req_wdata << (BYTE_WIDTH * 32'(req_off));
            end
        end else if (state_q == StBus) begin
            if (lsu_if.mem_ack) begin
                if (lsu_if.mem_err) begin
                    access_fault_d = 1'b1;
                    ldst_mask_d    = 4'b0000;
                end else if (rsp_is_load_q) begin
                    memory_out_d = lsu_if.mem_rdata;
                end
            end else if (expired) begin
                access_fault_d = 1'b1;
                ldst_mask_d    = 4'b0000;
            end else begin
                cnt_d = cnt_inc[CntWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            mem_we_q       <= 1'b0;
            mem_be_q       <= 4'b0000;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rsp_is_load_q  <= 1'b0;
            ldst_mask_q    <= 4'b0000;
            offset_q       <= 2'b00;
            unsigned_q     <= 1'b0;
            memory_out_q   <= '0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            mem_we_q       <= mem_we_d;
            mem_be_q       <= mem_be_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rsp_is_load_q  <= rsp_is_load_d;
            ldst_mask_q    <= ldst_mask_d;
            offset_q       <= offset_d;
            unsigned_q     <= unsigned_d;
            memory_out_q   <= memory_out_d;
            misaligned_q   <= misaligned_d;
            access_fault_q <= access_fault_d;
        end
    end

    assign lsu_if.mem_we           = mem_we_q;
    assign lsu_if.mem_be           = mem_be_q;
    assign lsu_if.mem_addr         = mem_addr_q;
    assign lsu_if.mem_wdata        = mem_wdata_q;
    assign lsu_if.rsp_is_load      = rsp_is_load_q;
    assign lsu_if.ldst_mask        = ldst_mask_q;
    assign lsu_if.offset           = offset_q;
    assign lsu_if.ldst_is_unsigned = unsigned_q;
    assign lsu_if.memory_out       = memory_out_q;
    assign lsu_if.misaligned       = misaligned_q;
    assign lsu_if.access_fault     = access_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses checked
// against a size/offset arithmetic model of the request rules.
module tb_load_store_unit;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    load_store_unit_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(32)) bus ();

    load_store_unit #(
        .BYTE_WIDTH    (8),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu_if(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        exc;
        logic [3:0]  size;
        logic [3:0]  be;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] lanes;
        logic        uns;
    } exp_t;

    typedef struct packed {
        int          req_cycles;
        int          rsp_lat;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        mreq_at_rsp;
        logic [3:0]  mask;
        logic [1:0]  off;
        logic        uns;
        logic        is_load;
        logic [31:0] mout;
        logic        mis;
        logic        fault;
        logic        bus_unstable;
        logic        rsp_unstable;
        logic        ready_seen;
        logic        back_idle;
    } obs_t;

    // Expected behaviour from access size in bytes and byte offset.
    function automatic exp_t model(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        exp_t m;
        int   nb;
        int   off;
        m   = '0;
        off = int'(a % 4);
        case (f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        m.exc   = (nb == 0) || (st && f3 >= 3'd4) || ((nb != 0) && (off % nb != 0));
        m.size  = 4'((1 << nb) - 1);
        m.be    = st ? 4'(((1 << nb) - 1) << off) : 4'hF;
        m.waddr = a - 32'(off);
        m.wdata = wd << (8 * off);
        for (int i = 0; i < 4; i++) if (m.be[i]) m.lanes[8*i +: 8] = 8'hFF;
        m.uns   = (f3 == 3'd4) || (f3 == 3'd5);
        return m;
    endfunction

    // Drives one request and collects what the DUT did; ack_delay < 0 means never ack.
    task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_delay, input bit err,
                              input logic [31:0] rdata, input int hold, output obs_t o);
        int n;
        int c;
        o = '0;
        o.rsp_lat = -1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        c = 0;
        while (c < 100) begin
            @(negedge clk);
            c++;
            if (bus.req_ready) o.ready_seen = 1'b1;
            if (bus.rsp_valid) begin
                o.rsp_lat = c;
                break;
            end
            if (bus.mem_req) begin
                if (o.req_cycles == 0) begin
                    o.be    = bus.mem_be;
                    o.addr  = bus.mem_addr;
                    o.wdata = bus.mem_wdata;
                    o.we    = bus.mem_we;
                end else if (bus.mem_be !== o.be || bus.mem_addr !== o.addr ||
                             bus.mem_wdata !== o.wdata || bus.mem_we !== o.we) begin
                    o.bus_unstable = 1'b1;
                end
                o.req_cycles++;
                if (ack_delay >= 0 && o.req_cycles == ack_delay + 1) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_err   = err;
                    bus.mem_rdata = rdata;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_ack   = 1'b0;
            bus.mem_err   = 1'b0;
            bus.mem_rdata = $urandom;
        end
        if (o.rsp_lat > 0) begin
            o.mreq_at_rsp = bus.mem_req;
            o.mask        = bus.ldst_mask;
            o.off         = bus.offset;
            o.uns         = bus.ldst_is_unsigned;
            o.is_load     = bus.rsp_is_load;
            o.mout        = bus.memory_out;
            o.mis         = bus.misaligned;
            o.fault       = bus.access_fault;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!bus.rsp_valid || bus.ldst_mask !== o.mask || bus.memory_out !== o.mout ||
                    bus.access_fault !== o.fault || bus.misaligned !== o.mis ||
                    bus.offset !== o.off || bus.rsp_is_load !== o.is_load)
                    o.rsp_unstable = 1'b1;
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
            @(negedge clk);
            o.back_idle = bus.req_ready && !bus.rsp_valid;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.mem_req, bus.mem_we, bus.rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 1000",
                     {bus.req_ready, bus.mem_req, bus.mem_we, bus.rsp_valid});
        end
        checks++;
        if ({bus.misaligned, bus.access_fault, bus.rsp_is_load, bus.ldst_is_unsigned} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.misaligned, bus.access_fault, bus.rsp_is_load, bus.ldst_is_unsigned});
        end
        checks++;
        if ({bus.mem_be, bus.ldst_mask, bus.offset} !== 10'b0) begin
            errors++;
            $display("FAIL reset_lanes: be=%b mask=%b off=%b want 0", bus.mem_be, bus.ldst_mask,
                     bus.offset);
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.memory_out} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h mout=%h want 0", bus.mem_addr,
                     bus.mem_wdata, bus.memory_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 32'hDEADBEEF, 0, o);
        checks++;
        if ({o.be, o.we, o.addr} !== {4'hF, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL lw_bus: be=%b we=%b addr=%h want 1111 0 00000100", o.be, o.we, o.addr);
        end
        checks++;
        if (o.rsp_lat !== 2 || o.req_cycles !== 1) begin
            errors++;
            $display("FAIL lw_latency: rsp=%0d req_cycles=%0d want 2 1", o.rsp_lat, o.req_cycles);
        end
        checks++;
        if ({o.mout, o.mask, o.off, o.is_load, o.fault, o.mis} !==
            {32'hDEADBEEF, 4'hF, 2'b00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lw_rsp: mout=%h mask=%b off=%b load=%b fault=%b mis=%b", o.mout,
                     o.mask, o.off, o.is_load, o.fault, o.mis);
        end
        checks++;
        if (o.ready_seen || !o.back_idle || o.mreq_at_rsp) begin
            errors++;
            $display("FAIL lw_handshake: ready_busy=%b idle=%b mreq_at_rsp=%b want 0 1 0",
                     o.ready_seen, o.back_idle, o.mreq_at_rsp);
        end
        checks++;
        if (bus.memory_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL idle_hold: mout=%h want deadbeef", bus.memory_out);
        end
    endtask

    task automatic test_store_byte();
        obs_t o;
        run_access(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 0, 1'b0, 32'h1234_5678, 0, o);
        checks++;
        if ({o.addr, o.be, o.we, o.wdata[31:24]} !== {32'h200, 4'b1000, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL sb_bus: addr=%h be=%b we=%b lane3=%h want 00000200 1000 1 a5",
                     o.addr, o.be, o.we, o.wdata[31:24]);
        end
        checks++;
        if ({o.mask, o.is_load, o.mout, o.off} !== {4'b0, 1'b0, 32'h0, 2'b11}) begin
            errors++;
            $display("FAIL sb_rsp: mask=%b load=%b mout=%h off=%b want 0000 0 0 11", o.mask,
                     o.is_load, o.mout, o.off);
        end
    endtask

    task automatic test_exceptions();
        obs_t o;
        run_access(1'b0, 3'b101, 32'h101, 32'h0, 0, 1'b0, 32'hFFFF_FFFF, 0, o);
        checks++;
        if (o.req_cycles !== 0 || o.rsp_lat !== 1 || o.mis !== 1'b1 || o.mask !== 4'b0 ||
            o.mout !== 32'h0 || o.uns !== 1'b1) begin
            errors++;
            $display("FAIL lhu_misaligned: cyc=%0d lat=%0d mis=%b mask=%b mout=%h uns=%b",
                     o.req_cycles, o.rsp_lat, o.mis, o.mask, o.mout, o.uns);
        end
        run_access(1'b1, 3'b100, 32'h0, 32'h55, 0, 1'b0, 32'h0, 0, o);
        checks++;
        if (o.req_cycles !== 0 || o.rsp_lat !== 1 || o.mis !== 1'b1 || o.is_load !== 1'b0) begin
            errors++;
            $display("FAIL store_f3_100: cyc=%0d lat=%0d mis=%b load=%b want 0 1 1 0",
                     o.req_cycles, o.rsp_lat, o.mis, o.is_load);
        end
        run_access(1'b0, 3'b011, 32'h40, 32'h0, 0, 1'b0, 32'h0, 0, o);
        checks++;
        if (o.req_cycles !== 0 || o.mis !== 1'b1) begin
            errors++;
            $display("FAIL illegal_f3_011: cyc=%0d mis=%b want 0 1", o.req_cycles, o.mis);
        end
    endtask

    task automatic test_bus_error();
        obs_t o;
        run_access(1'b0, 3'b001, 32'h102, 32'h0, 3, 1'b1, 32'hCAFE_F00D, 4, o);
        checks++;
        if (o.fault !== 1'b1 || o.mout !== 32'h0 || o.mask !== 4'b0 || o.off !== 2'b10) begin
            errors++;
            $display("FAIL lh_err_rsp: fault=%b mout=%h mask=%b off=%b want 1 0 0000 10",
                     o.fault, o.mout, o.mask, o.off);
        end
        checks++;
        if (o.rsp_lat !== 5 || o.req_cycles !== 4 || o.bus_unstable) begin
            errors++;
            $display("FAIL lh_err_timing: lat=%0d cyc=%0d unstable=%b want 5 4 0", o.rsp_lat,
                     o.req_cycles, o.bus_unstable);
        end
        checks++;
        if (o.rsp_unstable || !o.back_idle) begin
            errors++;
            $display("FAIL lh_err_hold: unstable=%b idle=%b want 0 1", o.rsp_unstable,
                     o.back_idle);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h40, 32'h0, -1, 1'b0, 32'h0, 0, o);
        checks++;
        if (o.req_cycles !== TO || o.rsp_lat !== TO + 1 || o.fault !== 1'b1 || o.mask !== 4'b0) begin
            errors++;
            $display("FAIL timeout: cyc=%0d lat=%0d fault=%b mask=%b want %0d %0d 1 0000",
                     o.req_cycles, o.rsp_lat, o.fault, o.mask, TO, TO + 1);
        end
        run_access(1'b0, 3'b010, 32'h44, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE, 0, o);
        checks++;
        if (o.rsp_lat !== TO + 1 || o.fault !== 1'b0 || o.mout !== 32'h0BAD_CAFE ||
            o.mask !== 4'hF) begin
            errors++;
            $display("FAIL ack_on_expiry: lat=%0d fault=%b mout=%h mask=%b want %0d 0 0badcafe 1111",
                     o.rsp_lat, o.fault, o.mout, o.mask, TO + 1);
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b010;
        bus.req_addr     = 32'h300;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bus: mem_req=%b want 1", bus.mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL async_reset: req/rsp/ready=%b want 001",
                     {bus.mem_req, bus.rsp_valid, bus.req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.rsp_valid, bus.req_ready} !== 3'b001 || bus.memory_out !== 32'h0) begin
            errors++;
            $display("FAIL stale_ack: req/rsp/ready=%b mout=%h want 001 0",
                     {bus.mem_req, bus.rsp_valid, bus.req_ready}, bus.memory_out);
        end
        run_access(1'b0, 3'b000, 32'h001, 32'h0, 0, 1'b0, 32'h0000_AB00, 0, o);
        checks++;
        if ({o.mask, o.off, o.uns, o.mout, o.fault} !== {4'b0001, 2'b01, 1'b0, 32'h0000_AB00, 1'b0}) begin
            errors++;
            $display("FAIL lb_after_reset: mask=%b off=%b uns=%b mout=%h fault=%b", o.mask, o.off,
                     o.uns, o.mout, o.fault);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        bit          st;
        bit          err;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          d;
        int          exp_lat;
        int          exp_cyc;
        bit          exp_fault;
        logic [3:0]  exp_mask;
        logic [31:0] exp_mout;
        for (int it = 0; it < 40; it++) begin
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd  = $urandom;
            rd  = $urandom;
            d   = $urandom_range(0, TO);
            if (d == TO) d = -1;
            err = (d >= 0) && ($urandom_range(0, 3) == 0);
            e   = model(st, f3, a, wd);
            if (e.exc) begin
                exp_lat = 1; exp_cyc = 0; exp_fault = 1'b0;
            end else if (d < 0) begin
                exp_lat = TO + 1; exp_cyc = TO; exp_fault = 1'b1;
            end else begin
                exp_lat = d + 2; exp_cyc = d + 1; exp_fault = err;
            end
            exp_mask = (e.exc || exp_fault || st) ? 4'b0 : e.size;
            exp_mout = (exp_mask != 4'b0) ? rd : 32'h0;
            run_access(st, f3, a, wd, d, err, rd, $urandom_range(0, 2), o);
            checks++;
            if (o.rsp_lat !== exp_lat || o.req_cycles !== exp_cyc || o.rsp_unstable ||
                o.bus_unstable) begin
                errors++;
                $display("FAIL rand%0d_timing: lat=%0d cyc=%0d unst=%b%b want %0d %0d 00", it,
                         o.rsp_lat, o.req_cycles, o.bus_unstable, o.rsp_unstable, exp_lat,
                         exp_cyc);
            end
            checks++;
            if ({o.mis, o.fault, o.mask, o.off, o.is_load, o.uns, o.mout} !==
                {e.exc, exp_fault, exp_mask, 2'(a % 4), !st, e.uns, exp_mout}) begin
                errors++;
                $display("FAIL rand%0d_rsp: mis=%b flt=%b mask=%b off=%b ld=%b uns=%b mout=%h want %b %b %b %b %b %b %h",
                         it, o.mis, o.fault, o.mask, o.off, o.is_load, o.uns, o.mout, e.exc,
                         exp_fault, exp_mask, 2'(a % 4), !st, e.uns, exp_mout);
            end
            if (!e.exc) begin
                checks++;
                if (o.be !== e.be || o.addr !== e.waddr || o.we !== st ||
                    (st && ((o.wdata & e.lanes) !== (e.wdata & e.lanes)))) begin
                    errors++;
                    $display("FAIL rand%0d_bus: be=%b addr=%h we=%b wdata=%h want %b %h %b %h",
                             it, o.be, o.addr, o.we, o.wdata & e.lanes, e.be, e.waddr, st,
                             e.wdata & e.lanes);
                end
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.mem_ack      = 1'b0;
        bus.mem_err      = 1'b0;
        bus.mem_rdata    = 32'h0;
        bus.rsp_ready    = 1'b0;
        test_reset();
        test_load_word();
        test_store_byte();
        test_exceptions();
        test_bus_error();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store front end between the execute stage and the data memory bus. It accepts one memory request at a time, checks alignment and funct3 legality, and drives a word-addressed bus with byte enables and a lane-shifted store word. It then returns the raw read word, together with `ldst_mask`, `offset` and `ldst_is_unsigned`, to the downstream memory access unit, which performs byte selection and sign/zero extension. A timeout watchdog guards against a bus that never acknowledges.

## Interface
- `BYTE_WIDTH`, 8, bits per byte lane; the data word is 4 lanes wide.
- `ADDR_WIDTH`, 32, byte address width.
- `TIMEOUT_CYCLES`, 255, bus cycles waited for `mem_ack` before a fault response; minimum 1.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when both are high.
- `req_is_store` in 1: 1 for a store, 0 for a load.
- `req_funct3` in 3: access size and signedness, RISC-V encoding.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 4*BYTE_WIDTH: store data, right-aligned.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_be` out 4: bus byte enables.
- `mem_addr` out ADDR_WIDTH: word address; bits [1:0] are always 0.
- `mem_wdata` out 4*BYTE_WIDTH: lane-shifted store data.
- `mem_ack` in 1: bus completion.
- `mem_err` in 1: bus error; valid only together with `mem_ack`.
- `mem_rdata` in 4*BYTE_WIDTH: read word; valid together with `mem_ack`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when both are high.
- `rsp_is_load` out 1: response belongs to a load.
- `ldst_mask` out 4: valid byte lanes after the downstream shift (0001 = byte, 0011 = half, 1111 = word, 0000 = no data).
- `offset` out 2: `req_addr[1:0]` of the request.
- `ldst_is_unsigned` out 1: zero-extend the load result.
- `memory_out` out 4*BYTE_WIDTH: raw bus read word, unshifted.
- `misaligned` out 1: alignment or illegal-funct3 exception.
- `access_fault` out 1: bus error or timeout.

## Operation
- funct3 decoding:
  - 000 → byte, mask 0001.
  - 001 → half, mask 0011.
  - 010 → word, mask 1111.
  - 100 → unsigned byte (LBU), mask 0001; legal for loads only.
  - 101 → unsigned half (LHU), mask 0011; legal for loads only.
  - Any other code, and 100/101 on a store, is illegal.
- Alignment rules: a half access requires `addr[0]==0`; a word access requires `addr[1:0]==00`.
- Store lane shifting:
  - `mem_be` = size mask << `addr[1:0]`.
  - `mem_wdata` = `req_wdata` << (8*`addr[1:0]`).
  - Bits of `mem_wdata` outside the enabled lanes are don't-care but deterministic.
- Load bus cycle: `mem_we`=0, `mem_be`=1111.
- FSM states:
  - IDLE: `req_ready`=1. On acceptance, a legal and aligned request goes to BUS. An illegal or misaligned request goes directly to RESP with `misaligned`=1 and no bus cycle.
  - BUS: `mem_req`=1 and bus outputs are held stable.
    - On `mem_ack` with `mem_err`=0: capture `mem_rdata` (loads only) and go to RESP.
    - On `mem_ack` with `mem_err`=1: set `access_fault`=1, `memory_out`=0, and go to RESP.
    - On watchdog expiry: drop `mem_req`, set `access_fault`=1, and go to RESP.
  - RESP: `rsp_valid`=1 and all response outputs are held until `rsp_ready`, then go to IDLE.
- Watchdog counter: cleared on entry to BUS and incremented each BUS cycle without `mem_ack`. It expires when the count reaches TIMEOUT_CYCLES. `mem_ack` in the expiry cycle wins: the access completes normally.
- Response field values:
  - Store responses and all exception responses: `ldst_mask`=0000 and `memory_out`=0, so the downstream unit outputs 0.
  - `offset` and `rsp_is_load` always reflect the request.
  - `ldst_is_unsigned` is 1 for funct3 100 and 101.
- Response outputs hold their last values in IDLE.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`=1.
  - `mem_req`, `mem_we`, `rsp_valid`, `misaligned`, `access_fault`, `rsp_is_load`, `ldst_is_unsigned` = 0.
  - `mem_be`, `ldst_mask`, `offset` = 0.
  - `mem_addr`, `mem_wdata`, `memory_out` = 0.
- All outputs are registered; none depends combinationally on an input.
- `req_ready` is 0 in BUS and RESP. A request offered then is not accepted and must be held by the source.
- Latency, with the request accepted at edge 0:
  - `mem_req` is high from cycle 1.
  - `mem_ack` in cycle 1 gives `rsp_valid` in cycle 2.
  - Each extra wait cycle adds 1.
- Exception path latency: `rsp_valid` in cycle 1.
- `mem_req` falls in the cycle after `mem_ack` is sampled; there are no back-to-back bus requests.
- Throughput: one access every 3 cycles at best, since the IDLE→BUS→RESP→IDLE round trip is fixed.
- Asynchronous reset mid-access deasserts `mem_req` and `rsp_valid` immediately. A later `mem_ack` in IDLE is ignored.

## Test plan
- LW at 0x100, `mem_rdata`=0xDEADBEEF, ack on the first bus cycle → `mem_be`=1111, `mem_addr`=0x100; at cycle 2, `rsp_valid`=1, `memory_out`=0xDEADBEEF, `ldst_mask`=1111, `offset`=00.
- SB of 0x000000A5 at 0x203 → `mem_addr`=0x200, `mem_be`=1000, `mem_wdata[31:24]`=0xA5, `mem_we`=1; response has `ldst_mask`=0000, `rsp_is_load`=0.
- LHU at 0x101 → no `mem_req`; `rsp_valid` at cycle 1 with `misaligned`=1. Store with funct3=100 → `misaligned`=1.
- LH at 0x102 with `mem_ack`+`mem_err` after 3 wait cycles → `access_fault`=1, `memory_out`=0; `rsp_valid` is held for 4 cycles while `rsp_ready`=0, outputs stable, then returns to IDLE.
- TIMEOUT_CYCLES=4 with no ack → `mem_req` is high for exactly 4 cycles, then `access_fault`=1. Separately, ack on the expiry cycle → normal response.
- Assert `rst_n`=0 during BUS → `mem_req`=0 immediately; a stale `mem_ack` after reset is ignored; the next LB at 0x001 returns `ldst_mask`=0001, `offset`=01, `ldst_is_unsigned`=0.
